csr_file: RTL and testbench

CSR_FILE -- requirements
Module: csr_file

---
 rtl/csr_pkg.sv | 33 +++
 rtl/csr_counter64.sv | 28 ++
 rtl/csr_file.sv | 172 +++++++++++++++++
 tb/tb_csr_file.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR address map, operation encodings and small decode helpers
// for the machine-mode CSR file.
package csr_pkg;

    localparam logic [11:0] CSR_MSCRATCH     = 12'h340;
    localparam logic [11:0] CSR_SCRATCH_BASE = 12'h7C0;
    localparam logic [11:0] CSR_MCYCLE       = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET     = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH      = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH    = 12'hB82;
    localparam logic [11:0] CSR_CYCLE        = 12'hC00;
    localparam logic [11:0] CSR_INSTRET      = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH       = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH     = 12'hC82;

    typedef enum logic [1:0] {
        CSR_NA    = 2'b00,
        CSR_PASS  = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_ctrl_e;

    typedef enum logic {
        CSR_SRC_REG = 1'b0,
        CSR_SRC_IMM = 1'b1
    } csr_src_e;

    // Addresses with [11:10] == 2'b11 are read-only by architecture.
    function automatic logic is_read_only(input logic [11:0] addr);
        return (addr[11:10] == 2'b11);
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// One 64-bit free-running counter whose halves can be overwritten;
// a write in a cycle suppresses that cycle's increment.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en,
    input  logic        wr_lo,
    input  logic [31:0] wr_lo_data,
    input  logic        wr_hi,
    input  logic [31:0] wr_hi_data,
    output logic [63:0] count
);

    // Counter state: write has priority over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 64'd0;
        end else if (wr_lo || wr_hi) begin
            count <= {(wr_hi ? wr_hi_data : count[63:32]),
                      (wr_lo ? wr_lo_data : count[31:0])};
        end else if (inc_en) begin
            count <= count + 64'd1;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: mscratch, custom scratch registers and the
// mcycle/minstret counters with read-only user shadows.
module csr_file
    import csr_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NUM_SCRATCH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            csr_valid_i,
    input  logic            flush_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_control_i,
    input  logic            csr_src_i,
    input  logic [4:0]      csr_src_idx_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic            retire_i,
    output logic            csr_valid_o,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            illegal_o
);

    localparam bit XLEN32 = (XLEN == 32);
    localparam int IDXW   = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

    logic [XLEN-1:0] mscratch;
    logic [XLEN-1:0] scratch [NUM_SCRATCH];
    logic [63:0]     mcycle;
    logic [63:0]     minstret;

    logic            accept;
    logic            write_attempt;
    logic            mapped;
    logic            illegal;
    logic            do_write;
    logic            sel_mscratch;
    logic            sel_scratch;
    logic [IDXW-1:0] scratch_idx;
    logic [XLEN-1:0] operand;
    logic [XLEN-1:0] old_val;
    logic [XLEN-1:0] new_val;
    logic [63:0]     new_val64;
    logic            cyc_wr_lo, cyc_wr_hi, ins_wr_lo, ins_wr_hi;
    logic [31:0]     wr_lo_data, wr_hi_data;

    assign accept        = csr_valid_i && !flush_i;
    assign operand       = (csr_src_i == CSR_SRC_IMM) ? XLEN'(csr_src_idx_i) : rs1_data_i;
    assign write_attempt = (csr_control_i == CSR_PASS) || (csr_src_idx_i != 5'd0);
    assign scratch_idx   = csr_addr_i[IDXW-1:0];

    // Address decode and read mux.
    always_comb begin
        mapped       = 1'b0;
        sel_mscratch = 1'b0;
        sel_scratch  = 1'b0;
        old_val      = '0;
        case (csr_addr_i)
            CSR_MSCRATCH: begin
                mapped       = 1'b1;
                sel_mscratch = 1'b1;
                old_val      = mscratch;
            end
            CSR_MCYCLE, CSR_CYCLE: begin
                mapped  = 1'b1;
                old_val = XLEN'(mcycle);
            end
            CSR_MINSTRET, CSR_INSTRET: begin
                mapped  = 1'b1;
                old_val = XLEN'(minstret);
            end
            CSR_MCYCLEH, CSR_CYCLEH: begin
                mapped  = XLEN32;
                old_val = XLEN32 ? XLEN'(mcycle[63:32]) : '0;
            end
            CSR_MINSTRETH, CSR_INSTRETH: begin
                mapped  = XLEN32;
                old_val = XLEN32 ? XLEN'(minstret[63:32]) : '0;
            end
            default: begin
                if ((csr_addr_i[11:4] == CSR_SCRATCH_BASE[11:4]) &&
                    ({1'b0, csr_addr_i[3:0]} < 5'(NUM_SCRATCH))) begin
                    mapped      = 1'b1;
                    sel_scratch = 1'b1;
                    old_val     = scratch[scratch_idx];
                end else begin
                    mapped = 1'b0;
                end
            end
        endcase
    end

    // Read-modify-write value for the selected operation.
    always_comb begin
        new_val = old_val;
        case (csr_control_i)
            CSR_PASS:  new_val = operand;
            CSR_SET:   new_val = old_val | operand;
            CSR_CLEAR: new_val = old_val & ~operand;
            default:   new_val = old_val;
        endcase
    end

    assign illegal  = !mapped || (csr_control_i == CSR_NA) ||
                      (is_read_only(csr_addr_i) && write_attempt);
    assign do_write = accept && !illegal && write_attempt;

    // On XLEN=64 the base counter address covers both halves at once.
    assign new_val64  = 64'(new_val);
    assign wr_lo_data = new_val64[31:0];
    assign wr_hi_data = XLEN32 ? new_val64[31:0] : new_val64[63:32];
    assign cyc_wr_lo  = do_write && (csr_addr_i == CSR_MCYCLE);
    assign cyc_wr_hi  = do_write && ((!XLEN32 && (csr_addr_i == CSR_MCYCLE)) ||
                                     (XLEN32 && (csr_addr_i == CSR_MCYCLEH)));
    assign ins_wr_lo  = do_write && (csr_addr_i == CSR_MINSTRET);
    assign ins_wr_hi  = do_write && ((!XLEN32 && (csr_addr_i == CSR_MINSTRET)) ||
                                     (XLEN32 && (csr_addr_i == CSR_MINSTRETH)));

    csr_counter64 u_mcycle (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .inc_en     (1'b1),
        .wr_lo      (cyc_wr_lo),
        .wr_lo_data (wr_lo_data),
        .wr_hi      (cyc_wr_hi),
        .wr_hi_data (wr_hi_data),
        .count      (mcycle)
    );

    csr_counter64 u_minstret (
        .clk        (clk_i),
        .rst_n      (rst_n_i),
        .inc_en     (retire_i),
        .wr_lo      (ins_wr_lo),
        .wr_lo_data (wr_lo_data),
        .wr_hi      (ins_wr_hi),
        .wr_hi_data (wr_hi_data),
        .count      (minstret)
    );

    // Scratch register storage.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mscratch <= '0;
            for (int k = 0; k < NUM_SCRATCH; k++) begin
                scratch[k] <= '0;
            end
        end else if (do_write && sel_mscratch) begin
            mscratch <= new_val;
        end else if (do_write && sel_scratch) begin
            scratch[scratch_idx] <= new_val;
        end
    end

    // Registered response, one cycle after accept.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            csr_valid_o <= 1'b0;
            csr_rdata_o <= '0;
            illegal_o   <= 1'b0;
        end else if (accept) begin
            csr_valid_o <= 1'b1;
            csr_rdata_o <= illegal ? '0 : old_val;
            illegal_o   <= illegal;
        end else begin
            csr_valid_o <= 1'b0;
            csr_rdata_o <= '0;
            illegal_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: driver pushes model responses, a monitor
// pops and compares one response per clock.
module tb_csr_file;
    import csr_pkg::*;

    localparam int XLEN = 32;
    localparam int NSCR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            csr_valid, flush, csr_src, retire;
    logic [11:0]     csr_addr;
    logic [1:0]      csr_control;
    logic [4:0]      csr_src_idx;
    logic [XLEN-1:0] rs1_data;
    logic            csr_valid_o, illegal_o;
    logic [XLEN-1:0] csr_rdata_o;

    typedef struct packed {
        logic        v;
        logic        ill;
        logic [31:0] rd;
    } resp_t;

    resp_t exp_q[$];
    resp_t mon_e;
    int    n_checks = 0;
    int    n_errors = 0;

    logic [63:0] m_cyc, m_ins;
    logic [31:0] m_msc;
    logic [31:0] m_scr [16];

    logic [11:0] addr_tbl [16] = '{12'h340, 12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3, 12'h7C4,
                                   12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                                   12'hC80, 12'hC82, 12'h341, 12'hB01};

    csr_file #(.XLEN(XLEN), .NUM_SCRATCH(NSCR)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .csr_valid_i   (csr_valid),
        .flush_i       (flush),
        .csr_addr_i    (csr_addr),
        .csr_control_i (csr_control),
        .csr_src_i     (csr_src),
        .csr_src_idx_i (csr_src_idx),
        .rs1_data_i    (rs1_data),
        .retire_i      (retire),
        .csr_valid_o   (csr_valid_o),
        .csr_rdata_o   (csr_rdata_o),
        .illegal_o     (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input resp_t act, input resp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got valid=%0b illegal=%0b rdata=%08h, want valid=%0b illegal=%0b rdata=%08h",
                     name, act.v, act.ill, act.rd, exp.v, exp.ill, exp.rd);
        end
    endtask

    task automatic model_reset();
        m_cyc = 64'd0;
        m_ins = 64'd0;
        m_msc = 32'd0;
        for (int i = 0; i < 16; i++) m_scr[i] = 32'd0;
    endtask

    // Architectural read of a CSR from the model; mapped=0 for holes.
    task automatic model_read(input logic [11:0] a, output bit mapped, output logic [31:0] v);
        mapped = 1'b1;
        v      = 32'd0;
        case (a)
            12'h340:          v = m_msc;
            12'hB00, 12'hC00: v = m_cyc[31:0];
            12'hB02, 12'hC02: v = m_ins[31:0];
            12'hB80, 12'hC80: v = m_cyc[63:32];
            12'hB82, 12'hC82: v = m_ins[63:32];
            default: begin
                if (a >= 12'h7C0 && a < 12'h7C0 + 12'(NSCR)) v = m_scr[a[3:0]];
                else mapped = 1'b0;
            end
        endcase
    endtask

    // Drive one cycle, push the expected response, advance the model.
    task automatic step(input bit v, input bit f, input logic [11:0] a, input logic [1:0] c,
                        input bit s, input logic [4:0] idx, input logic [31:0] rs, input bit ret);
        bit          mapped, wa, ill;
        logic [31:0] old, opnd, nv;
        logic [63:0] cyc_n, ins_n;
        csr_valid = v; flush = f; csr_addr = a; csr_control = c;
        csr_src = s; csr_src_idx = idx; rs1_data = rs; retire = ret;
        model_read(a, mapped, old);
        opnd = s ? {27'd0, idx} : rs;
        wa   = (c == CSR_PASS) || (idx != 5'd0);
        ill  = !mapped || (c == CSR_NA) || ((a[11:10] == 2'b11) && wa);
        if (v && !f) exp_q.push_back('{v: 1'b1, ill: ill, rd: ill ? 32'd0 : old});
        else         exp_q.push_back('{v: 1'b0, ill: 1'b0, rd: 32'd0});
        cyc_n = m_cyc + 64'd1;
        ins_n = m_ins + (ret ? 64'd1 : 64'd0);
        if (v && !f && !ill && wa) begin
            nv = (c == CSR_PASS) ? opnd : (c == CSR_SET) ? (old | opnd) : (old & ~opnd);
            case (a)
                12'h340: m_msc = nv;
                12'hB00: cyc_n = {m_cyc[63:32], nv};
                12'hB80: cyc_n = {nv, m_cyc[31:0]};
                12'hB02: ins_n = {m_ins[63:32], nv};
                12'hB82: ins_n = {nv, m_ins[31:0]};
                default: m_scr[a[3:0]] = nv;
            endcase
        end
        m_cyc = cyc_n;
        m_ins = ins_n;
        @(negedge clk);
    endtask

    task automatic rd(input logic [11:0] a);
        step(1'b1, 1'b0, a, CSR_SET, CSR_SRC_IMM, 5'd0, 32'd0, 1'b0);
    endtask

    // Monitor: one response per clock, compared against the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("resp", '{v: csr_valid_o, ill: illegal_o, rd: csr_rdata_o}, mon_e);
            end
        end
    end

    initial begin
        rst_n = 1'b0; csr_valid = 1'b0; flush = 1'b0; csr_addr = 12'h0;
        csr_control = CSR_NA; csr_src = CSR_SRC_REG; csr_src_idx = 5'd0;
        rs1_data = 32'd0; retire = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", '{v: csr_valid_o, ill: illegal_o, rd: csr_rdata_o}, '{v: 1'b0, ill: 1'b0, rd: 32'd0});
        rst_n = 1'b1;
        model_reset();

        rd(12'hB00);
        step(1, 0, 12'h340, CSR_PASS, CSR_SRC_REG, 5'd1, 32'hDEADBEEF, 0);
        step(1, 0, 12'h340, CSR_SET,  CSR_SRC_REG, 5'd5, 32'h0000FFFF, 0);
        rd(12'h340);
        step(1, 0, 12'h7C1, CSR_PASS,  CSR_SRC_REG, 5'd3, 32'h11112222, 0);
        step(1, 0, 12'h7C1, CSR_CLEAR, CSR_SRC_REG, 5'd0, 32'hFFFFFFFF, 0);
        rd(12'h7C1);
        step(1, 0, 12'hC00, CSR_PASS, CSR_SRC_REG, 5'd2, 32'h00000123, 0);
        step(1, 0, 12'h340, CSR_NA,   CSR_SRC_REG, 5'd2, 32'h00000456, 0);
        step(1, 0, 12'hC00, CSR_SET,  CSR_SRC_REG, 5'd0, 32'hFFFFFFFF, 0);
        rd(12'h340);
        step(1, 1, 12'h340, CSR_PASS, CSR_SRC_REG, 5'd1, 32'h0BADF00D, 0);
        rd(12'h340);
        step(1, 0, 12'hB80, CSR_PASS, CSR_SRC_IMM, 5'd0, 32'd0, 0);
        step(1, 0, 12'hB00, CSR_PASS, CSR_SRC_REG, 5'd1, 32'hFFFFFFFF, 0);
        step(0, 0, 12'h000, CSR_NA,   CSR_SRC_REG, 5'd0, 32'd0, 0);
        rd(12'hB80);
        for (int i = 1; i <= 10; i++)
            step(i == 5, 0, 12'hB02, CSR_PASS, CSR_SRC_REG, 5'd1, 32'd100, 1);
        rd(12'hB02);
        rd(12'hB82);
        step(1, 0, 12'hB02, CSR_PASS, CSR_SRC_REG, 5'd1, 32'hFFFFFFFE, 1);
        step(1, 0, 12'hB82, CSR_PASS, CSR_SRC_REG, 5'd1, 32'hFFFFFFFF, 1);
        step(0, 0, 12'h000, CSR_NA,   CSR_SRC_REG, 5'd0, 32'd0, 1);
        rd(12'hB02);
        rd(12'hB82);

        for (int i = 0; i < 400; i++) begin
            logic [4:0] idx;
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0,
                 addr_tbl[$urandom_range(0, 15)], 2'($urandom_range(0, 3)),
                 1'($urandom), idx, $urandom, 1'($urandom));
        end

        csr_valid = 1'b1; flush = 1'b0; csr_addr = 12'h340; csr_control = CSR_PASS;
        csr_src = CSR_SRC_REG; csr_src_idx = 5'd1; rs1_data = 32'h12345678;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_in_flight", '{v: csr_valid_o, ill: illegal_o, rd: csr_rdata_o}, '{v: 1'b0, ill: 1'b0, rd: 32'd0});
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        rd(12'h340);
        rd(12'hB00);
        rd(12'h7C1);
        step(0, 0, 12'h000, CSR_NA, CSR_SRC_REG, 5'd0, 32'd0, 0);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
